// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: read-after-write / write-after-write interlock for the
// general-purpose register file. A small counter per architectural register
// tracks writes that have issued but not yet written back. Issue is held
// while a source is pending or the destination counter is saturated.
// Writeback retires one write per cycle and flush clears all pending state.
module gpr_scoreboard #(
  parameter int RF_SIZE     = 5,
  parameter int CNT_WIDTH   = 2,
  parameter int STALL_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [RF_SIZE-1:0]     issue_rs1_i,
  input  logic                   issue_rs1_used_i,
  input  logic [RF_SIZE-1:0]     issue_rs2_i,
  input  logic                   issue_rs2_used_i,
  input  logic [RF_SIZE-1:0]     issue_rd_i,
  input  logic                   issue_rd_we_i,
  input  logic                   wb_valid_i,
  input  logic [RF_SIZE-1:0]     wb_rd_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [STALL_WIDTH-1:0] stall_cycles_o
);

  localparam int                   NREG    = 1 << RF_SIZE;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]   r_cnt [NREG];
  logic [CNT_WIDTH-1:0]   w_cnt_nxt [NREG];
  logic                   r_busy;
  logic                   r_err;
  logic [STALL_WIDTH-1:0] r_stall;

  logic w_rs1_pend;
  logic w_rs2_pend;
  logic w_rd_full;
  logic w_ready;
  logic w_fire;
  logic w_busy_nxt;
  logic w_underflow;
  logic w_stall;

  // Hazard detection looks only at registered counters, so a writeback in
  // the current cycle releases a stalled consumer on the following cycle,
  // matching the register file's write-then-registered-read timing.
  assign w_rs1_pend = issue_rs1_used_i && (issue_rs1_i != '0) && (r_cnt[issue_rs1_i] != '0);
  assign w_rs2_pend = issue_rs2_used_i && (issue_rs2_i != '0) && (r_cnt[issue_rs2_i] != '0);
  assign w_rd_full  = issue_rd_we_i && (issue_rd_i != '0) && (r_cnt[issue_rd_i] == CNT_MAX);

  // Ready deliberately ignores issue_valid_i to avoid a valid/ready loop.
  assign w_ready    = !flush_i && !w_rs1_pend && !w_rs2_pend && !w_rd_full;
  assign w_fire     = issue_valid_i && w_ready;
  assign w_stall    = issue_valid_i && !w_ready;

  // Writeback to an idle register is an accounting error; x0 never counts.
  assign w_underflow = wb_valid_i && !flush_i && (wb_rd_i != '0) && (r_cnt[wb_rd_i] == '0);

  // Next-state counter per register: flush clears, simultaneous inc/dec holds.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned, which would otherwise infer a latch.
    w_busy_nxt = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (flush_i) begin
        w_cnt_nxt[r] = '0;
      end else if (r != 0) begin
        if (w_fire && issue_rd_we_i && (issue_rd_i == RF_SIZE'(r))) begin
          if (!(wb_valid_i && (wb_rd_i == RF_SIZE'(r)) && (r_cnt[r] != '0)))
            w_cnt_nxt[r] = r_cnt[r] + 1'b1;
        end else if (wb_valid_i && (wb_rd_i == RF_SIZE'(r)) && (r_cnt[r] != '0)) begin
          w_cnt_nxt[r] = r_cnt[r] - 1'b1;
        end
      end
      w_busy_nxt = w_busy_nxt | (w_cnt_nxt[r] != '0);
    end
  end

  // State update: counters, busy flag, sticky error and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the counter array is control state, not data storage, so every
      // entry must be reset; a stale count would block issue forever.
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_busy <= w_busy_nxt;
      if (w_underflow) r_err <= 1'b1;
      if (w_stall && (r_stall != '1)) r_stall <= r_stall + 1'b1;
    end
  end

  assign issue_ready_o  = w_ready;
  assign busy_o         = r_busy;
  assign err_o          = r_err;
  assign stall_cycles_o = r_stall;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled before the next.
module tb_gpr_scoreboard;

  localparam int RF_SIZE     = 5;
  localparam int CNT_WIDTH   = 2;
  localparam int STALL_WIDTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  logic [RF_SIZE-1:0]     issue_rs1_i;
  logic                   issue_rs1_used_i;
  logic [RF_SIZE-1:0]     issue_rs2_i;
  logic                   issue_rs2_used_i;
  logic [RF_SIZE-1:0]     issue_rd_i;
  logic                   issue_rd_we_i;
  logic                   wb_valid_i;
  logic [RF_SIZE-1:0]     wb_rd_i;
  logic                   flush_i;
  logic                   busy_o;
  logic                   err_o;
  logic [STALL_WIDTH-1:0] stall_cycles_o;

  int n_tests = 0;
  int n_fail  = 0;

  gpr_scoreboard #(
    .RF_SIZE    (RF_SIZE),
    .CNT_WIDTH  (CNT_WIDTH),
    .STALL_WIDTH(STALL_WIDTH)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs1_used_i(issue_rs1_used_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_rs2_used_i(issue_rs2_used_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rd_we_i   (issue_rd_we_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .stall_cycles_o  (stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_rs1_i      = '0;
    issue_rs1_used_i = 1'b0;
    issue_rs2_i      = '0;
    issue_rs2_used_i = 1'b0;
    issue_rd_i       = '0;
    issue_rd_we_i    = 1'b0;
    wb_valid_i       = 1'b0;
    wb_rd_i          = '0;
    flush_i          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_wr(input logic [RF_SIZE-1:0] rd);
    idle();
    issue_valid_i = 1'b1;
    issue_rd_i    = rd;
    issue_rd_we_i = 1'b1;
  endtask

  task automatic writeback(input logic [RF_SIZE-1:0] rd);
    idle();
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy",  busy_o, 0);
    check("rst_err",   err_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    check("rst_ready", issue_ready_o, 1);

    // RAW on x5: producer fires, consumer stalls two cycles
    issue_wr(5'd5);
    #1 check("raw_prod_ready", issue_ready_o, 1);
    tick();
    idle();
    issue_valid_i = 1'b1; issue_rs1_i = 5'd5; issue_rs1_used_i = 1'b1;
    #1 check("raw_cons_stall", issue_ready_o, 0);
    check("raw_busy", busy_o, 1);
    tick();
    check("raw_stall1", stall_cycles_o, 1);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    #1 check("raw_no_bypass", issue_ready_o, 0);
    tick();
    wb_valid_i = 1'b0;
    #1 check("raw_release", issue_ready_o, 1);
    check("raw_stall2", stall_cycles_o, 2);
    check("raw_idle", busy_o, 0);
    tick();

    // x0 is never tracked and never an error
    do_reset();
    issue_wr(5'd0);
    #1 check("x0_wr_ready", issue_ready_o, 1);
    tick();
    idle();
    issue_valid_i = 1'b1; issue_rs1_i = 5'd0; issue_rs1_used_i = 1'b1;
    #1 check("x0_rd_ready", issue_ready_o, 1);
    check("x0_busy", busy_o, 0);
    tick();
    writeback(5'd0);
    tick();
    idle();
    #1 check("x0_wb_err", err_o, 0);
    check("x0_wb_busy", busy_o, 0);

    // WAW saturation on x7
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd7);
      #1 check($sformatf("waw_fire%0d", i), issue_ready_o, 1);
      tick();
    end
    issue_wr(5'd7);
    #1 check("waw_full", issue_ready_o, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd7;
    #1 check("waw_full_wb", issue_ready_o, 0);
    tick();
    wb_valid_i = 1'b0;
    #1 check("waw_after_wb", issue_ready_o, 1);
    wb_valid_i = 1'b1; wb_rd_i = 5'd7;
    tick();
    wb_valid_i = 1'b0;
    #1 check("waw_hold_ready", issue_ready_o, 1);
    tick();
    #1 check("waw_refull", issue_ready_o, 0);
    check("waw_stall", stall_cycles_o, 1);
    for (int i = 0; i < 3; i++) begin
      writeback(5'd7);
      tick();
    end
    idle();
    #1 check("waw_drain_busy", busy_o, 0);
    check("waw_drain_err", err_o, 0);

    // Flush overrides concurrent issue and writeback
    do_reset();
    issue_wr(5'd3);
    tick();
    issue_wr(5'd9);
    tick();
    idle();
    #1 check("fl_busy_pre", busy_o, 1);
    issue_valid_i = 1'b1; issue_rd_i = 5'd4; issue_rd_we_i = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; flush_i = 1'b1;
    #1 check("fl_ready", issue_ready_o, 0);
    tick();
    idle();
    #1 check("fl_busy", busy_o, 0);
    check("fl_err", err_o, 0);
    check("fl_stall", stall_cycles_o, 1);
    issue_valid_i = 1'b1;
    issue_rs1_i = 5'd4; issue_rs1_used_i = 1'b1;
    issue_rs2_i = 5'd9; issue_rs2_used_i = 1'b1;
    #1 check("fl_cleared", issue_ready_o, 1);
    tick();

    // Sticky underflow error
    do_reset();
    writeback(5'd12);
    tick();
    idle();
    #1 check("uf_set", err_o, 1);
    issue_wr(5'd12);
    tick();
    writeback(5'd12);
    tick();
    idle();
    #1 check("uf_sticky", err_o, 1);
    check("uf_busy", busy_o, 0);
    do_reset();
    #1 check("uf_rst", err_o, 0);

    // Stall counter saturation, then reset mid-stall
    issue_wr(5'd2);
    tick();
    idle();
    issue_valid_i = 1'b1; issue_rs1_i = 5'd2; issue_rs1_used_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("sat_mid", stall_cycles_o, 10);
    for (int i = 0; i < 10; i++) tick();
    check("sat_hold", stall_cycles_o, 15);
    check("sat_ready", issue_ready_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("sat_rst_stall", stall_cycles_o, 0);
    check("sat_rst_busy", busy_o, 0);
    check("sat_rst_ready", issue_ready_o, 1);
    check("sat_rst_err", err_o, 0);

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
- Read-after-write / write-after-write interlock controller for the 2^RF_SIZE-entry general-purpose register file.
- Sits between decode/issue and the register file.
- Tracks outstanding writes per architectural register and holds issue (issue_ready_o low) while a source register, or a saturated destination, has writes still in flight.
- Writeback retires pending writes; flush discards all pending state.

Parameters:
- RF_SIZE, 5, register index width; 2^RF_SIZE tracked registers.
- CNT_WIDTH, 2, width of per-register pending-write counter; max in-flight writes per register = 2^CNT_WIDTH-1.
- STALL_WIDTH, 32, width of stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- issue_valid_i  input  1  decode presents an instruction.
- issue_ready_o  output  1  instruction may issue this cycle (combinational).
- issue_rs1_i  input  RF_SIZE  source 1 index.
- issue_rs1_used_i  input  1  instruction reads rs1.
- issue_rs2_i  input  RF_SIZE  source 2 index.
- issue_rs2_used_i  input  1  instruction reads rs2.
- issue_rd_i  input  RF_SIZE  destination index.
- issue_rd_we_i  input  1  instruction writes rd.
- wb_valid_i  input  1  writeback completes this cycle (same cycle as register file write).
- wb_rd_i  input  RF_SIZE  writeback destination index.
- flush_i  input  1  discard all in-flight writes.
- busy_o  output  1  registered; 1 when any counter is nonzero.
- err_o  output  1  sticky writeback-underflow flag.
- stall_cycles_o  output  STALL_WIDTH  saturating count of stalled cycles.

Behaviour:
- State: cnt[0..2^RF_SIZE-1], each CNT_WIDTH bits. Also busy_o, err_o, stall_cycles_o.
- Reset (rst=1 at edge):
  - all cnt = 0
  - busy_o = 0, err_o = 0, stall_cycles_o = 0
  - issue_ready_o reads 1 while cnt are 0 and flush_i=0
  - rst has priority over every other input.
- pend(r) = (r != 0) && (cnt[r] != 0). Register x0 is never pending and never counted.
- issue_ready_o = !flush_i && !(rs1_used && pend(rs1)) && !(rs2_used && pend(rs2)) && !(rd_we && rd != 0 && cnt[rd] == 2^CNT_WIDTH-1).
  - Depends only on registered cnt: a writeback does not bypass into ready.
  - Stalled consumer issues the cycle after wb_valid_i.
  - Matches the register file's write-before-registered-read timing.
  - issue_ready_o must not depend on issue_valid_i.
- fire = issue_valid_i && issue_ready_o.
- Per-register next-state, priority rst > flush_i > normal:
  - inc = fire && rd_we && rd==r && r!=0
  - dec = wb_valid_i && wb_rd==r && r!=0 && cnt[r]!=0
  - inc && !dec: cnt+1. dec && !inc: cnt-1. Both or neither: hold (simultaneous issue and writeback to same rd nets zero).
- Underflow: wb_valid_i with wb_rd!=0 and cnt[wb_rd]==0, no flush, no rst.
  - cnt stays 0; err_o set to 1 next edge and held until rst.
  - wb to x0 is always ignored and never an error.
- flush_i=1:
  - all cnt = 0 next edge; concurrent issue/wb ignored.
  - issue_ready_o forced 0 that cycle; no underflow flagged.
- WAW: multiple outstanding writes to one rd permitted up to counter max. rd is pending until all have retired.
- busy_o: registered OR of next-state cnt; updates same edge as cnt.
- stall_cycles_o: +1 each cycle with issue_valid_i && !issue_ready_o (including flush cycles). Saturates at all-ones; cleared only by rst.
- Latency: counter update 1 cycle after fire/wb. Ready is combinational from state.

Test Plan:
- Reset, then issue rd=5 we=1 fire → next cycle cnt[5]=1, busy_o=1. Issue rs1=5 used → ready=0. wb rd=5 → ready=1 the following cycle; stall_cycles_o=2 if held valid throughout.
- Issue rd=0 we=1, then rs1=0 used → ready=1 every cycle, busy_o=0. wb rd=0 with cnt 0 → err_o stays 0.
- CNT_WIDTH=2: three fires to rd=7 → cnt=3. Fourth issue rd=7 → ready=0. Same cycle wb rd=7 → ready=1 next cycle. Fire+wb rd=7 in one cycle → cnt holds.
- Pending rd=3 and rd=9, flush_i=1 with concurrent fire rd=4 and wb rd=3 → next cycle all cnt=0, busy_o=0, err_o=0; cnt[4]=0.
- wb rd=12 with cnt[12]=0 → err_o=1 next cycle, persists through further traffic; rst clears to 0.
- Force stall_cycles_o to all-ones via long stall (STALL_WIDTH=4, 20 stalled cycles) → holds 15. rst mid-stall with pending rd=2 → cnt, counter and outputs 0 next cycle.
